// File: rtl/eth_pcm_rx.sv
// Ethernet PCM receiver: strips the frame header, stores the payload in a two-bank buffer and replays 8 channels per strobe.
// Optional EtherType qualification is enabled by defining ETH_PCM_RX_ETYPE_CHECK_EN.
//
// state  | meaning
// R_IDLE | waiting for start of frame
// R_HDR  | counting header bytes
// R_PAY  | writing payload words into wr_bank
// R_EOF  | payload complete, waiting for end of frame
// R_DROP | discarding the rest of a rejected frame
// P_IDLE | waiting for pcm_stb
// P_READ | reading one frame, one channel per clock
module eth_pcm_rx #(
  parameter int          HDR_BYTES     = 14,
  parameter int          PAYLOAD_BYTES = 512,
  parameter int          CHANNELS      = 8,
  parameter logic [15:0] ETHERTYPE     = 16'h88B5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_stb,
  input  logic [7:0]  rx_data,
  input  logic        rx_sof,
  input  logic        rx_eof,
  input  logic        rx_ok,
  input  logic        pcm_stb,
  output logic        pcm_valid,
  output logic [2:0]  pcm_chan,
  output logic [15:0] pcm_data,
  output logic [1:0]  buf_full,
  output logic [7:0]  drop_cnt,
  output logic [7:0]  underrun_cnt
);

  localparam int FRAMES = PAYLOAD_BYTES / (2 * CHANNELS);

`ifdef ETH_PCM_RX_ETYPE_CHECK_EN
  localparam bit ETYPE_CHECK = 1'b1;
`else
  localparam bit ETYPE_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {R_IDLE, R_HDR, R_PAY, R_EOF, R_DROP} rx_state_t;
  typedef enum logic       {P_IDLE, P_READ} pl_state_t;

  rx_state_t   rx_state, rx_next;
  pl_state_t   pl_state, pl_next;

  logic [15:0] mem [0:511];
  logic [15:0] mem_q;
  logic        zero_q;

  logic [9:0]  byte_cnt, byte_cnt_next;
  logic [7:0]  lo_byte;
  logic [7:0]  etype_hi;
  logic        etype_bad;
  logic        sof;
  logic        wr_bank;
  logic        drop_inc, full_set, mem_we, lo_we;

  logic [2:0]  ch, ch_next;
  logic [4:0]  frame_idx;
  logic        rd_bank;
  logic        under_q, under_now;
  logic        rd_en, under_inc, full_clr, frame_inc;

  assign sof       = rx_sof & rx_stb;
  assign etype_bad = ETYPE_CHECK && (byte_cnt == 10'(HDR_BYTES - 1)) &&
                     ({etype_hi, rx_data} != ETHERTYPE);

  // ---------------- receive FSM ----------------
  always_comb begin
    rx_next       = rx_state;
    byte_cnt_next = byte_cnt;
    drop_inc      = 1'b0;
    full_set      = 1'b0;
    mem_we        = 1'b0;
    lo_we         = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (sof) begin
          byte_cnt_next = 10'd1;
          rx_next       = buf_full[wr_bank] ? R_DROP : R_HDR;
        end
      end
      R_HDR: begin
        if (sof || rx_eof) begin
          drop_inc = 1'b1;
          rx_next  = R_IDLE;
        end else if (rx_stb) begin
          byte_cnt_next = byte_cnt + 10'd1;
          if (etype_bad) begin
            rx_next = R_DROP;
          end else if (byte_cnt == 10'(HDR_BYTES - 1)) begin
            rx_next       = R_PAY;
            byte_cnt_next = '0;
          end
        end
      end
      R_PAY: begin
        if (sof || rx_eof) begin
          drop_inc = 1'b1;
          rx_next  = R_IDLE;
        end else if (rx_stb) begin
          byte_cnt_next = byte_cnt + 10'd1;
          mem_we        = byte_cnt[0];
          lo_we         = ~byte_cnt[0];
          if (byte_cnt == 10'(PAYLOAD_BYTES - 1))
            rx_next = R_EOF;
        end
      end
      R_EOF: begin
        // any further byte means the frame is too long
        if (rx_stb) begin
          drop_inc = 1'b1;
          rx_next  = R_IDLE;
        end else if (rx_eof) begin
          full_set = rx_ok;
          drop_inc = ~rx_ok;
          rx_next  = R_IDLE;
        end
      end
      R_DROP: begin
        if (sof || rx_eof) begin
          drop_inc = 1'b1;
          rx_next  = R_IDLE;
        end
      end
      default: rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= R_IDLE;
      byte_cnt <= '0;
      lo_byte  <= '0;
      etype_hi <= '0;
      wr_bank  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      rx_state <= rx_next;
      byte_cnt <= byte_cnt_next;
      if (lo_we)
        lo_byte <= rx_data;
      if (rx_state == R_HDR && rx_stb && byte_cnt == 10'(HDR_BYTES - 2))
        etype_hi <= rx_data;
      if (full_set)
        wr_bank <= ~wr_bank;
      if (drop_inc)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // ---------------- playback FSM ----------------
  // underrun decision is taken on the first read cycle so a flag set by a coincident rx_eof is seen
  assign under_now = (ch == 3'd0) ? ~buf_full[rd_bank] : under_q;

  always_comb begin
    pl_next   = pl_state;
    ch_next   = ch;
    rd_en     = 1'b0;
    under_inc = 1'b0;
    full_clr  = 1'b0;
    frame_inc = 1'b0;
    case (pl_state)
      P_IDLE: begin
        if (pcm_stb) begin
          pl_next = P_READ;
          ch_next = 3'd0;
        end
      end
      P_READ: begin
        rd_en     = 1'b1;
        under_inc = (ch == 3'd0) && under_now;
        ch_next   = ch + 3'd1;
        if (ch == 3'(CHANNELS - 1)) begin
          pl_next = P_IDLE;
          ch_next = 3'd0;
          if (!under_now) begin
            frame_inc = 1'b1;
            full_clr  = (frame_idx == 5'(FRAMES - 1));
          end
        end
      end
      default: pl_next = P_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pl_state     <= P_IDLE;
      ch           <= '0;
      under_q      <= 1'b0;
      frame_idx    <= '0;
      rd_bank      <= 1'b0;
      underrun_cnt <= '0;
      pcm_valid    <= 1'b0;
      pcm_chan     <= '0;
      zero_q       <= 1'b1;
    end else begin
      pl_state  <= pl_next;
      ch        <= ch_next;
      pcm_valid <= rd_en;
      if (rd_en) begin
        under_q  <= under_now;
        pcm_chan <= ch;
        zero_q   <= under_now;
      end
      if (frame_inc)
        frame_idx <= frame_idx + 5'd1;
      if (full_clr)
        rd_bank <= ~rd_bank;
      if (under_inc)
        underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

  // set and clear always target different banks
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (full_set && wr_bank == b[0])
          buf_full[b] <= 1'b1;
        else if (full_clr && rd_bank == b[0])
          buf_full[b] <= 1'b0;
      end
    end
  end

  // ---------------- buffer RAM ----------------
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[{wr_bank, byte_cnt[8:1]}] <= {rx_data, lo_byte};
    if (rd_en)
      mem_q <= mem[{rd_bank, frame_idx, ch}];
  end

  assign pcm_data = zero_q ? 16'h0000 : mem_q;

endmodule

// File: tb/tb_eth_pcm_rx.sv
// Directed self-checking bench for eth_pcm_rx: framing, drops, underrun and two-bank playback order.
module tb_eth_pcm_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_stb, rx_sof, rx_eof, rx_ok, pcm_stb;
  logic [7:0]  rx_data;
  logic        pcm_valid;
  logic [2:0]  pcm_chan;
  logic [15:0] pcm_data;
  logic [1:0]  buf_full;
  logic [7:0]  drop_cnt, underrun_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  eth_pcm_rx dut (
    .clk          (clk),
    .rst          (rst),
    .rx_stb       (rx_stb),
    .rx_data      (rx_data),
    .rx_sof       (rx_sof),
    .rx_eof       (rx_eof),
    .rx_ok        (rx_ok),
    .pcm_stb      (pcm_stb),
    .pcm_valid    (pcm_valid),
    .pcm_chan     (pcm_chan),
    .pcm_data     (pcm_data),
    .buf_full     (buf_full),
    .drop_cnt     (drop_cnt),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_stb = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_ok = 1'b0;
    rx_data = 8'h00; pcm_stb = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit first, input int gap);
    rx_stb = 1'b1; rx_sof = first; rx_data = b;
    tick();
    rx_stb = 1'b0; rx_sof = 1'b0;
    repeat (gap) tick();
  endtask

  // header bytes 12/13 carry et; payload byte n = n + seed
  task automatic send_frame(input logic [15:0] et, input int npay, input bit ok,
                            input bit do_eof, input logic [7:0] seed, input int gap);
    for (int i = 0; i < 14; i++) begin
      if (i == 12)      send_byte(et[15:8], 1'b0, gap);
      else if (i == 13) send_byte(et[7:0], 1'b0, gap);
      else              send_byte(8'(8'hA0 + i), i == 0, gap);
    end
    for (int n = 0; n < npay; n++) send_byte(8'(n + int'(seed)), 1'b0, gap);
    if (do_eof) begin
      rx_eof = 1'b1; rx_ok = ok;
      tick();
      rx_eof = 1'b0; rx_ok = 1'b0;
      tick();
    end
  endtask

  task automatic play(input logic [7:0] seed, input int f, input bit zero, input bit dbl);
    logic [15:0] exp_d;
    int w;
    pcm_stb = 1'b1;
    tick();
    pcm_stb = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      w = f * 8 + k;
      exp_d = zero ? 16'h0000 : {8'(2 * w + 1 + int'(seed)), 8'(2 * w + int'(seed))};
      chk("pcm_valid", 32'(pcm_valid), 32'd1);
      chk("pcm_chan", 32'(pcm_chan), 32'(k));
      chk("pcm_data", 32'(pcm_data), 32'(exp_d));
      if (dbl && k == 2) pcm_stb = 1'b1;
      tick();
      pcm_stb = 1'b0;
    end
    chk("valid_end", 32'(pcm_valid), 32'd0);
    if (dbl) begin
      tick(); tick();
      chk("valid_after_dbl", 32'(pcm_valid), 32'd0);
    end
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_valid", 32'(pcm_valid), 32'd0);
    chk("rst_chan", 32'(pcm_chan), 32'd0);
    chk("rst_data", 32'(pcm_data), 32'd0);
    chk("rst_full", 32'(buf_full), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_under", 32'(underrun_cnt), 32'd0);

    // good frame, then 32 strobes drain bank 0
    send_frame(16'h88B5, 512, 1'b1, 1'b1, 8'h00, 0);
    chk("good_full", 32'(buf_full), 32'd1);
    chk("good_drop", 32'(drop_cnt), 32'd0);
    for (int f = 0; f < 32; f++) play(8'h00, f, 1'b0, 1'b0);
    chk("drain_full", 32'(buf_full), 32'd0);
    chk("drain_under", 32'(underrun_cnt), 32'd0);

    // bad FCS then underrun strobe
    send_frame(16'h88B5, 512, 1'b0, 1'b1, 8'h00, 0);
    chk("fcs_drop", 32'(drop_cnt), 32'd1);
    chk("fcs_full", 32'(buf_full), 32'd0);
    play(8'h00, 0, 1'b1, 1'b0);
    chk("fcs_under", 32'(underrun_cnt), 32'd1);

    // short and long frames, then a good frame lands in bank 0
    do_reset();
    send_frame(16'h88B5, 511, 1'b1, 1'b1, 8'h00, 0);
    chk("short_drop", 32'(drop_cnt), 32'd1);
    send_frame(16'h88B5, 513, 1'b1, 1'b1, 8'h00, 1);
    chk("long_drop", 32'(drop_cnt), 32'd2);
    chk("long_full", 32'(buf_full), 32'd0);
    send_frame(16'h88B5, 512, 1'b1, 1'b1, 8'h10, 2);
    chk("len_good_full", 32'(buf_full), 32'd1);
    chk("len_good_drop", 32'(drop_cnt), 32'd2);
    play(8'h10, 0, 1'b0, 1'b0);

    // overrun: third frame dropped, banks play in order
    do_reset();
    send_frame(16'h88B5, 512, 1'b1, 1'b1, 8'h00, 0);
    send_frame(16'h88B5, 512, 1'b1, 1'b1, 8'h40, 0);
    chk("ovr_full2", 32'(buf_full), 32'd3);
    send_frame(16'h88B5, 512, 1'b1, 1'b1, 8'h80, 0);
    chk("ovr_full3", 32'(buf_full), 32'd3);
    chk("ovr_drop", 32'(drop_cnt), 32'd1);
    for (int f = 0; f < 32; f++) play(8'h00, f, 1'b0, 1'b0);
    chk("ovr_mid_full", 32'(buf_full), 32'd2);
    for (int f = 0; f < 32; f++) play(8'h40, f, 1'b0, 1'b0);
    chk("ovr_end_full", 32'(buf_full), 32'd0);
    chk("ovr_under", 32'(underrun_cnt), 32'd0);

    // reset mid-payload, then good frame and double strobe
    do_reset();
    send_frame(16'h88B5, 200, 1'b1, 1'b0, 8'h00, 0);
    do_reset();
    chk("abort_full", 32'(buf_full), 32'd0);
    chk("abort_drop", 32'(drop_cnt), 32'd0);
    send_frame(16'h88B5, 512, 1'b1, 1'b1, 8'h22, 0);
    chk("abort_good_full", 32'(buf_full), 32'd1);
    chk("abort_good_drop", 32'(drop_cnt), 32'd0);
    chk("abort_good_under", 32'(underrun_cnt), 32'd0);
    play(8'h22, 0, 1'b0, 1'b1);
    play(8'h22, 1, 1'b0, 1'b0);
    chk("dbl_under", 32'(underrun_cnt), 32'd0);

    // EtherType qualification
    do_reset();
    send_frame(16'h0800, 512, 1'b1, 1'b1, 8'h00, 0);
`ifdef ETH_PCM_RX_ETYPE_CHECK_EN
    chk("etype_bad_drop", 32'(drop_cnt), 32'd1);
    chk("etype_bad_full", 32'(buf_full), 32'd0);
    send_frame(16'h88B5, 512, 1'b1, 1'b1, 8'h00, 0);
    chk("etype_ok_full", 32'(buf_full), 32'd1);
    chk("etype_ok_drop", 32'(drop_cnt), 32'd1);
`else
    chk("etype_any_drop", 32'(drop_cnt), 32'd0);
    chk("etype_any_full", 32'(buf_full), 32'd1);
    send_frame(16'h88B5, 512, 1'b1, 1'b1, 8'h00, 0);
    chk("etype_ok_full", 32'(buf_full), 32'd3);
    chk("etype_ok_drop", 32'(drop_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
